// File: rtl/xfer_pkg.sv
// Shared types and defaults for the transfer sequencer.
// Optional stall timeout is enabled with the XFER_TIMEOUT_EN macro.
package xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_LOC       = 64;
  localparam int DEF_ADD_WIDTH = 6;
  localparam int DEF_MOVE_LAT  = 2;
  localparam int DEF_TIMEOUT   = 255;

  // A burst must carry at least one word and fit in one memory.
  function automatic logic len_ok(input int unsigned len, input int unsigned loc);
    return (len != 0) && (len <= loc);
  endfunction

endpackage

// File: rtl/xfer_lat_line.sv
// LAT-deep 1-bit delay line with synchronous clear; turns ren1 into wen2.
module xfer_lat_line #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sr <= '0;
    else if (clr)
      sr <= '0;
    else
      sr <= (sr << 1) | LAT'(din);
  end

  assign dout = sr[LAT-1];

endmodule

// File: rtl/xfer_seq_ctrl.sv
// Fill / move / drain sequencer for the source memory -> bridge -> sink memory path.
// Defining XFER_TIMEOUT_EN adds a stall timeout and the timeout output.
module xfer_seq_ctrl
  import xfer_pkg::*;
#(
  parameter int LOC       = DEF_LOC,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int MOVE_LAT  = DEF_MOVE_LAT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 rclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   burst_len,
  input  logic                 abort,
  input  logic                 src_valid,
  input  logic                 sink_ready,
  output logic                 wen1,
  output logic                 ren1,
  output logic                 wen2,
  output logic                 ren2,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 aborted,
  output logic [2:0]           state_o
`ifdef XFER_TIMEOUT_EN
  , output logic               timeout
`endif
);

  localparam int CW = ADD_WIDTH + 1;

  state_t        state;
  logic [CW-1:0] len, fill_cnt, rd_cnt, mv_cnt, dr_cnt;
  logic          ren1_q;
  logic          to_hit;
  logic          take_abort;

  assign take_abort = (state != S_IDLE) && (abort || to_hit);

`ifdef XFER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic          stalling;
  logic [SW-1:0] stall_cnt;

  assign stalling = ((state == S_FILL) && !src_valid) || ((state == S_DRAIN) && !sink_ready);
  assign to_hit   = stalling && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout   <= to_hit;
      stall_cnt <= (stalling && !take_abort) ? stall_cnt + 1'b1 : '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  xfer_lat_line #(.LAT(MOVE_LAT)) u_lat (
    .clk  (rclk),
    .rst  (rst),
    .clr  (take_abort),
    .din  (ren1_q),
    .dout (wen2)
  );

  // Abort wins over any phase completion in the same cycle, so no done follows it.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      fill_cnt <= '0;
      rd_cnt   <= '0;
      mv_cnt   <= '0;
      dr_cnt   <= '0;
      ren1_q   <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      aborted <= 1'b0;
      if (take_abort) begin
        state    <= S_IDLE;
        fill_cnt <= '0;
        rd_cnt   <= '0;
        mv_cnt   <= '0;
        dr_cnt   <= '0;
        ren1_q   <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (len_ok(32'(burst_len), LOC)) begin
                len   <= burst_len;
                state <= S_FILL;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (src_valid) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (fill_cnt + 1'b1 == len) begin
                state  <= S_MOVE;
                ren1_q <= 1'b1;
              end
            end
          end
          S_MOVE: begin
            if (ren1_q) begin
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_cnt == len - 1'b1)
                ren1_q <= 1'b0;
            end
            if (wen2) begin
              mv_cnt <= mv_cnt + 1'b1;
              if (mv_cnt == len - 1'b1)
                state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (sink_ready) begin
              dr_cnt <= dr_cnt + 1'b1;
              if (dr_cnt == len - 1'b1) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            fill_cnt <= '0;
            rd_cnt   <= '0;
            mv_cnt   <= '0;
            dr_cnt   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign wen1    = (state == S_FILL) && src_valid;
  assign ren2    = (state == S_DRAIN) && sink_ready;
  assign ren1    = ren1_q;
  assign busy    = (state != S_IDLE);
  assign state_o = state;

endmodule

// File: doc/xfer_seq_ctrl.md
Name: xfer_seq_ctrl

Overview:
Single-clock sequencer for the low-to-high-speed transfer path (source memory -> rate bridge -> sink memory). It generates the four memory enables (wen1, ren1, wen2, ren2) to run one burst through three phases: fill the source memory, move the data across, and drain the sink memory. It sits beside the transfer datapath and replaces hand-driven enables from the testbench or host.

Parameters:
LOC, 64, depth of each memory in words; maximum burst length.
ADD_WIDTH, 6, log2(LOC); counters and burst_len are ADD_WIDTH+1 bits wide.
MOVE_LAT, 2, cycles from ren1 to valid data at the sink-memory input; valid range 1..7.
TIMEOUT, 255, stall limit in cycles; used only with TIMEOUT_EN.

Ports:
rclk  in  1  sole clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to run a burst; sampled only in IDLE.
burst_len  in  ADD_WIDTH+1  words per burst; captured on an accepted start.
abort  in  1  synchronous abort of the current burst.
src_valid  in  1  source has a word on din this cycle.
sink_ready  in  1  consumer accepts a word from dout this cycle.
wen1  out  1  source-memory write enable.
ren1  out  1  source-memory read enable.
wen2  out  1  sink-memory write enable.
ren2  out  1  sink-memory read enable.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a burst completes.
cfg_err  out  1  one-cycle pulse when a start is rejected.
aborted  out  1  one-cycle pulse when an abort is taken.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; all counters clear to 0.
  - All outputs are 0, and state_o reads IDLE.
- Enables:
  - wen1 and ren2 are combinational qualifications of the current state and the handshake inputs.
  - ren1 and wen2 are registered.
  - done, cfg_err and aborted are registered one-cycle pulses.
- State encoding: IDLE=0, FILL=1, MOVE=2, DRAIN=3, DONE=4.
- IDLE:
  - start with 1 <= burst_len <= LOC: capture the length, go to FILL next cycle.
  - start with burst_len == 0 or burst_len > LOC: stay in IDLE, cfg_err=1 on the next cycle.
- FILL:
  - wen1 = src_valid.
  - fill_cnt increments on each accepted word.
  - When the accepted word makes fill_cnt equal to len, go to MOVE.
  - src_valid low: hold, no write.
- MOVE:
  - ren1=1 for exactly len consecutive cycles.
  - wen2 is ren1 delayed by MOVE_LAT cycles through a shift register.
  - mv_cnt counts wen2 pulses; when it reaches len, go to DRAIN.
  - Total MOVE time is len + MOVE_LAT cycles.
- DRAIN:
  - ren2 = sink_ready.
  - dr_cnt counts accepted reads; the read with dr_cnt == len-1 goes to DONE.
- DONE:
  - done=1 for one cycle, counters clear, return to IDLE.
  - busy is still 1 in DONE and drops in the following IDLE cycle.
- start while busy: ignored, no error.
- abort (any non-IDLE state):
  - Next cycle: state is IDLE, all enables are 0, the delay line and counters clear, aborted=1.
  - abort in the same cycle as the last word of a phase takes priority; no done pulse.
  - abort in IDLE has no effect.
- Reset mid-burst: returns to IDLE immediately; memory pointers are the memories' own responsibility via the shared rst.
- Counter arithmetic is unsigned ADD_WIDTH+1 bits and never wraps, because len <= LOC.

Optional Feature:
Macro: XFER_TIMEOUT_EN.
- Defined:
  - A stall counter runs in FILL while src_valid is low, and in DRAIN while sink_ready is low.
  - It clears on any accepted word or on a state change.
  - When it reaches TIMEOUT, the block behaves as an abort: next cycle IDLE with aborted=1.
  - Adds output timeout (1 bit): a one-cycle pulse coincident with that aborted.
- Undefined: no stall counter, no timeout port; FILL and DRAIN wait indefinitely.

Decomposition:
- Shared package xfer_pkg: state enum (IDLE..DONE, 3 bits), LOC, ADD_WIDTH and MOVE_LAT defaults, and a len_ok(len) check constant function.
- One sub-module, xfer_lat_line: a MOVE_LAT-deep 1-bit shift register with synchronous clear. It produces wen2 from ren1.

Test Plan:
1. burst_len=8, src_valid and sink_ready held 1. Expect: 8 wen1 cycles, ren1 for 8 cycles, wen2 for 8 cycles starting MOVE_LAT=2 cycles after the first ren1, 8 ren2 cycles. done pulses once, and busy spans 8+10+8+1 cycles.
2. burst_len=0, then burst_len=65. Expect: cfg_err pulses once for each, busy stays 0, all enables stay 0.
3. burst_len=4, src_valid toggling 1,0,1,0,... Expect: exactly 4 wen1 pulses, each coincident with src_valid=1, then MOVE.
4. abort asserted on the 3rd ren1 cycle of a 16-word burst. Expect next cycle: IDLE, all enables 0, aborted=1, no done; a following start with burst_len=2 completes normally.
5. burst_len=64 with sink_ready stalled for 10 cycles mid-DRAIN. Expect: ren2 low during the stall, 64 total ren2, done once. With XFER_TIMEOUT_EN and TIMEOUT=5, the same stall instead gives timeout=1 and aborted=1 on the same cycle.
6. rst pulsed asynchronously mid-MOVE. Expect: all outputs 0 before the next rclk edge, state_o=0.
